// File: rtl/coin_return_ctrl.sv
// coin_return_ctrl: returns held credit as coins, largest first, after an idle timeout or a user request.
// Ports:
//   clk, reset_n      - clock, synchronous active-low reset
//   i_input_coin      - coin-insert strobes (activity restarts the idle timer)
//   i_select_item     - item-select strobes (activity restarts the idle timer)
//   i_trigger_return  - user request to return the credit now
//   current_total     - credit held by the parent
//   i_return_ack      - parent took the offered coin and deducts it from current_total
//   o_return_coin     - one-hot offered coin
//   o_return_valid    - offer valid
//   o_sub_value       - value of the offered coin
//   wait_time         - remaining idle cycles before auto-return
//   o_busy            - return sequence in progress
//   o_done            - one-cycle pulse at the end of a return sequence
module coin_return_ctrl #(
    parameter int NUM_COINS = 3,
    parameter int NUM_ITEMS = 4,
    parameter int TOTAL_BITS = 31,
    parameter int TIMER_BITS = 32,
    parameter int WAIT_TIME = 100,
    parameter logic [16*NUM_COINS-1:0] COIN_VALUES = {16'd1000, 16'd500, 16'd100}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic [NUM_ITEMS-1:0]  i_select_item,
    input  logic                  i_trigger_return,
    input  logic [TOTAL_BITS-1:0] current_total,
    input  logic                  i_return_ack,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic                  o_return_valid,
    output logic [TOTAL_BITS-1:0] o_sub_value,
    output logic [TIMER_BITS-1:0] wait_time,
    output logic                  o_busy,
    output logic                  o_done
);
    typedef enum logic [1:0] {COUNT, RETURN, SETTLE, DONE} state_t;

    localparam logic [TOTAL_BITS-1:0] MIN_COIN = TOTAL_BITS'(COIN_VALUES[15:0]);
    localparam logic [TIMER_BITS-1:0] WAIT_INIT = TIMER_BITS'(WAIT_TIME);

    state_t                state, state_nx;
    logic [TIMER_BITS-1:0] wait_nx;
    logic [NUM_COINS-1:0]  coin_nx, offer_coin;
    logic [TOTAL_BITS-1:0] sub_nx, offer_val;
    logic                  valid_nx, done_nx, has_coin;

    // Coins ascend in value, so the last one that fits is the largest.
    always_comb begin
        offer_coin = '0;
        offer_val = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (TOTAL_BITS'(COIN_VALUES[16*i +: 16]) <= current_total) begin
                offer_coin = NUM_COINS'(1) << i;
                offer_val = TOTAL_BITS'(COIN_VALUES[16*i +: 16]);
            end
        end
    end

    assign has_coin = current_total >= MIN_COIN;

    always_comb begin
        state_nx = state;
        wait_nx = wait_time;
        coin_nx = o_return_coin;
        valid_nx = o_return_valid;
        sub_nx = o_sub_value;
        done_nx = 1'b0;
        case (state)
            COUNT: begin
                // Trigger outranks coin/select activity; with nothing to return
                // only an explicit trigger ends the idle wait.
                if ((i_trigger_return || wait_time == '0) && has_coin) begin
                    state_nx = RETURN;
                    coin_nx = offer_coin;
                    valid_nx = 1'b1;
                    sub_nx = offer_val;
                end else if (i_trigger_return) begin
                    state_nx = DONE;
                    done_nx = 1'b1;
                    wait_nx = WAIT_INIT;
                end else if (|i_input_coin || |i_select_item) begin
                    wait_nx = WAIT_INIT;
                end else if (wait_time != '0) begin
                    wait_nx = wait_time - 1'b1;
                end
            end
            RETURN: begin
                if (i_return_ack) begin
                    state_nx = SETTLE;
                    coin_nx = '0;
                    valid_nx = 1'b0;
                    sub_nx = '0;
                end
            end
            SETTLE: begin
                // The parent has deducted the coin by now; decide on the fresh total.
                if (has_coin) begin
                    state_nx = RETURN;
                    coin_nx = offer_coin;
                    valid_nx = 1'b1;
                    sub_nx = offer_val;
                end else begin
                    state_nx = DONE;
                    done_nx = 1'b1;
                    wait_nx = WAIT_INIT;
                end
            end
            default: state_nx = COUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= COUNT;
            wait_time <= WAIT_INIT;
            o_return_coin <= '0;
            o_return_valid <= 1'b0;
            o_sub_value <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state <= state_nx;
            wait_time <= wait_nx;
            o_return_coin <= coin_nx;
            o_return_valid <= valid_nx;
            o_sub_value <= sub_nx;
            o_busy <= state_nx != COUNT;
            o_done <= done_nx;
        end
    end
endmodule
